sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The block SHALL have parameter Data_width, default 8, meaning the word width in bits.
REQ-002 The block SHALL have parameter Depth, default 16, meaning the number of entries; it SHALL be a power of two and at least 4.
REQ-003 The block SHALL have parameter Address_width, default 4, equal to log2(Depth).
REQ-004 The block SHALL have parameter Almost_full_th, default 14, meaning Almost_full asserts when Count >= this value.
REQ-005 The block SHALL have parameter Almost_empty_th, default 2, meaning Almost_empty asserts when Count <= this value.
REQ-006 The block SHALL have parameter Fwft, default 0, where 0 selects standard read mode and 1 selects first-word-fall-through.
REQ-007 The block SHALL have one clock and an asynchronous active-high reset: Clk, input, 1 bit, the single clock, all logic on its rising edge.
REQ-008 The block SHALL have Rst, input, 1 bit, asynchronous active-high reset.
REQ-009 The block SHALL have Wrdata, input, Data_width bits, the write data.
REQ-010 The block SHALL have Push, input, 1 bit, the write request.
REQ-011 The block SHALL have Pop, input, 1 bit, the read request.
REQ-012 The block SHALL have Rdata, output, Data_width bits, the read data.
REQ-013 The block SHALL have Full and Empty, each an output of 1 bit, giving occupancy status.
REQ-014 The block SHALL have Almost_full and Almost_empty, each an output of 1 bit, giving threshold status.
REQ-015 The block SHALL have Count, output, Address_width+1 bits, giving the current occupancy from 0 to Depth.
REQ-016 The block SHALL have Overflow and Underflow, each an output of 1 bit, as sticky error flags.

Function
REQ-017 A push SHALL be accepted when Push=1 and either Full=0 or an accepted pop occurs in the same cycle; an accepted push writes Wrdata at the write pointer, and the write pointer increments modulo Depth.
REQ-018 A pop SHALL be accepted when Pop=1 and Empty=0; an accepted pop increments the read pointer modulo Depth.
REQ-019 Count SHALL update on every edge as follows: +1 for push only, -1 for pop only, and unchanged for both or neither.
REQ-020 Full SHALL equal (Count==Depth) and Empty SHALL equal (Count==0); both SHALL be registered and consistent with Count in the same cycle.
REQ-021 The pointers SHALL be Address_width+1 bits; Full and Empty derive from MSB difference with equal lower bits, and wrap-around SHALL be seamless.
REQ-022 With Fwft=0, Rdata SHALL load the head entry on the edge that accepts a pop, giving one-cycle latency; otherwise Rdata SHALL hold its value.
REQ-023 With Fwft=1, Rdata SHALL present the head entry combinationally whenever Empty=0, and a pop SHALL advance to the next entry; Rdata is don't-care while Empty=1.
REQ-024 A push with Push=1 while Full=1 and no accepted pop SHALL be dropped, with no memory write and no pointer or Count change, and SHALL set Overflow.
REQ-025 Pop=1 while Empty=1 SHALL be ignored and SHALL set Underflow; a simultaneous push is still accepted.
REQ-026 Overflow and Underflow SHALL remain set until reset.
REQ-027 Almost_full and Almost_empty SHALL be registered and computed from the next-state Count.

Reset
REQ-028 Asserting Rst SHALL immediately clear the pointers, Count, Rdata, Overflow and Underflow to 0, set Empty=1, Almost_empty=1, Full=0 and Almost_full=0, and discard any in-flight push or pop.
REQ-029 Memory contents SHALL NOT be reset.
REQ-030 The first accepted operation SHALL occur on the first rising Clk edge after Rst deasserts.

Structure
REQ-031 Shared package sync_fifo_pkg SHALL hold the default width and depth constants and the Fwft mode encodings.
REQ-032 Storage SHALL be a sub-module sync_fifo_mem: single clock, one write port and one read port, with a registered read used when Fwft=0 and a combinational read used when Fwft=1.
REQ-033 Pointer, count and flag logic SHALL reside in sync_fifo itself.

Verification
REQ-034 After reset, push 16 words 0x01..0x10 -> Full=1, Count=16, Almost_full=1 from Count 14; a 17th push -> dropped and Overflow=1.
REQ-035 From full, pop 16 times with Fwft=0 -> Rdata 0x01..0x10, each one cycle after its pop, then Empty=1; a 17th pop -> Underflow=1.
REQ-036 Simultaneous Push=1 and Pop=1 at Count=16 -> Count stays 16, the oldest word is read, and the new word is stored.
REQ-037 Run 40 push/pop pairs at Count 3 -> data order is preserved across pointer wrap, and Count stays 3.
REQ-038 Fwft=1: push 0xA5 into an empty FIFO -> Rdata=0xA5 the next cycle with no pop; pop -> Empty=1.
REQ-039 Assert Rst mid-burst at Count=9 -> outputs take their reset values immediately, and the next push of 0x3C is read back as 0x3C.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared constants for the synchronous FIFO: default geometry, flag thresholds
// and the encodings of the read-mode selector.
package sync_fifo_pkg;

   localparam int DefaultDataWidth     = 8;
   localparam int DefaultDepth         = 16;
   localparam int DefaultAddrWidth     = 4;
   localparam int DefaultAlmostFullTh  = 14;
   localparam int DefaultAlmostEmptyTh = 2;

   // Read-mode selector: standard mode has one cycle of read latency after a
   // pop; fall-through mode shows the head word as soon as the FIFO is not empty.
   typedef enum int {
      FwftStandard    = 0,
      FwftFallThrough = 1
   } fwftMode_e;

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for the FIFO: one write port and one read port on a single
// clock. The read side is registered in standard mode and combinational in
// fall-through mode. The array itself has no reset; only the read register has one.
module sync_fifo_mem
   import sync_fifo_pkg::*;
#(
   parameter int Data_width    = DefaultDataWidth,
   parameter int Address_width = DefaultAddrWidth,
   parameter int Fwft          = FwftStandard
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic                     wrEn_i,
   input  logic [Address_width-1:0] wrAddr_i,
   input  logic [Data_width-1:0]    wrData_i,
   input  logic                     rdEn_i,
   input  logic [Address_width-1:0] rdAddr_i,
   output logic [Data_width-1:0]    rdData_o
);

   localparam int Entries = 1 << Address_width;

   logic [Data_width-1:0] mem_q [Entries];
   logic [Data_width-1:0] rdData_q;

   // Write the incoming word into the array. There is no reset, so the contents survive Rst.
   always_ff @(posedge Clk) begin
      if (wrEn_i) begin
         mem_q[wrAddr_i] <= wrData_i;
      end
   end

   // Load the head word into the read register when a pop is accepted. This is a
   // read-before-write, so a simultaneous write to the same slot still returns the old word.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         rdData_q <= '0;
      end else if (rdEn_i) begin
         rdData_q <= mem_q[rdAddr_i];
      end
   end

   // Select the read path for the mode. The read register becomes dead logic in fall-through mode.
   assign rdData_o = (Fwft == FwftFallThrough) ? mem_q[rdAddr_i] : rdData_q;

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count, full/empty and threshold flags, and
// sticky overflow/underflow error flags. The pointers carry one extra wrap bit,
// so full and empty can be told apart when the lower address bits are equal.
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter int Data_width      = DefaultDataWidth,
   parameter int Depth           = DefaultDepth,
   parameter int Address_width   = DefaultAddrWidth,
   parameter int Almost_full_th  = DefaultAlmostFullTh,
   parameter int Almost_empty_th = DefaultAlmostEmptyTh,
   parameter int Fwft            = FwftStandard
) (
   input  logic                   Clk,
   input  logic                   Rst,
   input  logic [Data_width-1:0]  Wrdata,
   input  logic                   Push,
   input  logic                   Pop,
   output logic [Data_width-1:0]  Rdata,
   output logic                   Full,
   output logic                   Empty,
   output logic                   Almost_full,
   output logic                   Almost_empty,
   output logic [Address_width:0] Count,
   output logic                   Overflow,
   output logic                   Underflow
);

   localparam logic [Address_width:0] CountOne   = {{Address_width{1'b0}}, 1'b1};
   localparam logic [Address_width:0] AlmostFull = Almost_full_th[Address_width:0];
   localparam logic [Address_width:0] AlmostEmpt = Almost_empty_th[Address_width:0];

   logic [Address_width:0] wrPtr_q, wrPtr_d;
   logic [Address_width:0] rdPtr_q, rdPtr_d;
   logic [Address_width:0] count_q, count_d;
   logic                   full_q, full_d;
   logic                   empty_q, empty_d;
   logic                   almostFull_q, almostFull_d;
   logic                   almostEmpty_q, almostEmpty_d;
   logic                   overflow_q, overflow_d;
   logic                   underflow_q, underflow_d;
   logic                   pushAccept;
   logic                   popAccept;
   logic [Data_width-1:0]  memRdData;

   // Decide which requests are accepted and compute the next pointers, count and flags.
   // A push into a full FIFO is accepted when a pop frees a slot in the same cycle.
   always_comb begin
      popAccept  = Pop && !empty_q;
      pushAccept = Push && (!full_q || popAccept);

      wrPtr_d = pushAccept ? (wrPtr_q + CountOne) : wrPtr_q;
      rdPtr_d = popAccept  ? (rdPtr_q + CountOne) : rdPtr_q;

      count_d = count_q;
      case ({pushAccept, popAccept})
         2'b10:   count_d = count_q + CountOne;
         2'b01:   count_d = count_q - CountOne;
         default: count_d = count_q;
      endcase

      full_d  = (wrPtr_d[Address_width] != rdPtr_d[Address_width]) &&
                (wrPtr_d[Address_width-1:0] == rdPtr_d[Address_width-1:0]);
      empty_d = (wrPtr_d == rdPtr_d);

      almostFull_d  = (count_d >= AlmostFull);
      almostEmpty_d = (count_d <= AlmostEmpt);

      overflow_d  = overflow_q  || (Push && full_q && !popAccept);
      underflow_d = underflow_q || (Pop && empty_q);
   end

   // Hold the pointers, count and every status flag. Reset leaves the FIFO
   // empty with both error flags clear.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         wrPtr_q       <= '0;
         rdPtr_q       <= '0;
         count_q       <= '0;
         full_q        <= 1'b0;
         empty_q       <= 1'b1;
         almostFull_q  <= 1'b0;
         almostEmpty_q <= 1'b1;
         overflow_q    <= 1'b0;
         underflow_q   <= 1'b0;
      end else begin
         wrPtr_q       <= wrPtr_d;
         rdPtr_q       <= rdPtr_d;
         count_q       <= count_d;
         full_q        <= full_d;
         empty_q       <= empty_d;
         almostFull_q  <= almostFull_d;
         almostEmpty_q <= almostEmpty_d;
         overflow_q    <= overflow_d;
         underflow_q   <= underflow_d;
      end
   end

   sync_fifo_mem #(
      .Data_width    (Data_width),
      .Address_width (Address_width),
      .Fwft          (Fwft)
   ) u_mem (
      .Clk      (Clk),
      .Rst      (Rst),
      .wrEn_i   (pushAccept),
      .wrAddr_i (wrPtr_q[Address_width-1:0]),
      .wrData_i (Wrdata),
      .rdEn_i   (popAccept),
      .rdAddr_i (rdPtr_q[Address_width-1:0]),
      .rdData_o (memRdData)
   );

   // In fall-through mode the output is forced to zero while empty, so reset
   // visibly clears it even though the array itself is not reset.
   assign Rdata        = ((Fwft == FwftFallThrough) && empty_q) ? '0 : memRdData;
   assign Full         = full_q;
   assign Empty        = empty_q;
   assign Almost_full  = almostFull_q;
   assign Almost_empty = almostEmpty_q;
   assign Count        = count_q;
   assign Overflow     = overflow_q;
   assign Underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo. The same stimulus drives a standard-mode
// instance and a fall-through instance side by side, and both are checked
// against a queue-based model of the FIFO.
module tb_sync_fifo;

   localparam int DW    = 8;
   localparam int Depth = 16;
   localparam int AW    = 4;
   localparam int AfTh  = 14;
   localparam int AeTh  = 2;

   logic          Clk = 1'b0;
   logic          Rst;
   logic          Push;
   logic          Pop;
   logic [DW-1:0] Wrdata;

   logic [DW-1:0] stdRdata, fwRdata;
   logic          stdFull, fwFull, stdEmpty, fwEmpty;
   logic          stdAf, fwAf, stdAe, fwAe;
   logic [AW:0]   stdCount, fwCount;
   logic          stdOvf, fwOvf, stdUnf, fwUnf;

   int compared   = 0;
   int mismatched = 0;

   logic [DW-1:0] modelQ[$];
   logic [DW-1:0] modelRd;
   logic          modelOvf;
   logic          modelUnf;

   sync_fifo #(
      .Data_width(DW), .Depth(Depth), .Address_width(AW),
      .Almost_full_th(AfTh), .Almost_empty_th(AeTh), .Fwft(0)
   ) dutStd (
      .Clk(Clk), .Rst(Rst), .Wrdata(Wrdata), .Push(Push), .Pop(Pop),
      .Rdata(stdRdata), .Full(stdFull), .Empty(stdEmpty),
      .Almost_full(stdAf), .Almost_empty(stdAe), .Count(stdCount),
      .Overflow(stdOvf), .Underflow(stdUnf)
   );

   sync_fifo #(
      .Data_width(DW), .Depth(Depth), .Address_width(AW),
      .Almost_full_th(AfTh), .Almost_empty_th(AeTh), .Fwft(1)
   ) dutFwft (
      .Clk(Clk), .Rst(Rst), .Wrdata(Wrdata), .Push(Push), .Pop(Pop),
      .Rdata(fwRdata), .Full(fwFull), .Empty(fwEmpty),
      .Almost_full(fwAf), .Almost_empty(fwAe), .Count(fwCount),
      .Overflow(fwOvf), .Underflow(fwUnf)
   );

   // Free-running clock with a 10-unit period.
   always #5 Clk = ~Clk;

   // Count one comparison, and report it and count a failure if it does not match.
   task automatic compare(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Advance the model by one clock edge with the given request inputs.
   task automatic modelStep(input logic push, input logic pop, input logic [DW-1:0] data);
      bit isFull  = (modelQ.size() == Depth);
      bit isEmpty = (modelQ.size() == 0);
      bit popA    = pop && !isEmpty;
      bit pushA   = push && (!isFull || popA);
      if (push && !pushA) modelOvf = 1'b1;
      if (pop && isEmpty) modelUnf = 1'b1;
      if (popA) modelRd = modelQ.pop_front();
      if (pushA) modelQ.push_back(data);
   endtask

   // Compare every output of both instances against the model.
   task automatic checkOutput(input string phase);
      int n = modelQ.size();
      compare({phase, ":std.Count"},  32'(stdCount), n);
      compare({phase, ":std.Full"},   32'(stdFull),  32'(n == Depth));
      compare({phase, ":std.Empty"},  32'(stdEmpty), 32'(n == 0));
      compare({phase, ":std.AF"},     32'(stdAf),    32'(n >= AfTh));
      compare({phase, ":std.AE"},     32'(stdAe),    32'(n <= AeTh));
      compare({phase, ":std.Ovf"},    32'(stdOvf),   32'(modelOvf));
      compare({phase, ":std.Unf"},    32'(stdUnf),   32'(modelUnf));
      compare({phase, ":std.Rdata"},  32'(stdRdata), 32'(modelRd));
      compare({phase, ":fw.Count"},   32'(fwCount),  n);
      compare({phase, ":fw.Full"},    32'(fwFull),   32'(n == Depth));
      compare({phase, ":fw.Empty"},   32'(fwEmpty),  32'(n == 0));
      compare({phase, ":fw.AF"},      32'(fwAf),     32'(n >= AfTh));
      compare({phase, ":fw.AE"},      32'(fwAe),     32'(n <= AeTh));
      compare({phase, ":fw.Ovf"},     32'(fwOvf),    32'(modelOvf));
      compare({phase, ":fw.Unf"},     32'(fwUnf),    32'(modelUnf));
      if (n > 0) compare({phase, ":fw.Rdata"}, 32'(fwRdata), 32'(modelQ[0]));
   endtask

   // Drive one cycle of requests at the falling edge, then check just after the rising edge.
   task automatic applyStimulus(input logic push, input logic pop, input logic [DW-1:0] data,
                                input string phase);
      @(negedge Clk);
      Push   = push;
      Pop    = pop;
      Wrdata = data;
      @(posedge Clk);
      modelStep(push, pop, data);
      #1 checkOutput(phase);
   endtask

   // Assert reset between clock edges. Check that it takes effect at once and
   // still holds after two clock edges, then release it at a falling edge.
   task automatic applyReset(input string phase);
      @(negedge Clk);
      #2;
      Rst  = 1'b1;
      Push = 1'b0;
      Pop  = 1'b0;
      #1;
      modelQ.delete();
      modelRd  = '0;
      modelOvf = 1'b0;
      modelUnf = 1'b0;
      checkOutput({phase, ".async"});
      repeat (2) @(posedge Clk);
      #1 checkOutput({phase, ".held"});
      @(negedge Clk);
      Rst = 1'b0;
   endtask

   // Directed scenarios first, then randomized traffic at several push/pop biases.
   initial begin
      int pushPct [4] = '{70, 30, 50, 90};
      Rst      = 1'b0;
      Push     = 1'b0;
      Pop      = 1'b0;
      Wrdata   = '0;
      modelRd  = '0;
      modelOvf = 1'b0;
      modelUnf = 1'b0;

      applyReset("reset");

      // Fill with 1..16, then push a 17th word, which must be dropped.
      for (int i = 1; i <= Depth; i++) applyStimulus(1'b1, 1'b0, DW'(i), "fill");
      applyStimulus(1'b1, 1'b0, 8'h77, "overflow");

      // Drain with standard-mode latency, then pop once more while empty.
      for (int i = 1; i <= Depth; i++) applyStimulus(1'b0, 1'b1, 8'h00, "drain");
      compare("drain.lastWord", 32'(stdRdata), 32'h10);
      applyStimulus(1'b0, 1'b1, 8'h00, "underflow");

      // Refill, then push and pop together while full.
      for (int i = 0; i < Depth; i++) applyStimulus(1'b1, 1'b0, DW'($urandom), "refill");
      applyStimulus(1'b1, 1'b1, 8'h99, "fullPushPop");
      compare("fullPushPop.count", 32'(stdCount), 32'd16);

      // Drop to three entries, then run paired push/pop across the pointer wrap.
      for (int i = 0; i < Depth - 3; i++) applyStimulus(1'b0, 1'b1, 8'h00, "toThree");
      for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b1, DW'($urandom), "wrapPairs");
      compare("wrapPairs.count", 32'(stdCount), 32'd3);

      // Fall-through: one word in an empty FIFO appears with no pop issued.
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 8'h00, "toEmpty");
      applyStimulus(1'b1, 1'b0, 8'hA5, "fwftPush");
      applyStimulus(1'b0, 1'b0, 8'h00, "fwftIdle");
      compare("fwftIdle.rdata", 32'(fwRdata), 32'hA5);
      applyStimulus(1'b0, 1'b1, 8'h00, "fwftPop");

      // Reset in the middle of a burst, then check the FIFO works from clean.
      for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0, DW'($urandom), "burst");
      applyReset("midReset");
      applyStimulus(1'b1, 1'b0, 8'h3C, "postResetPush");
      applyStimulus(1'b0, 1'b1, 8'h00, "postResetPop");
      compare("postReset.rdata", 32'(stdRdata), 32'h3C);

      // Randomized traffic with varying bias, so the FIFO runs through both full and empty.
      foreach (pushPct[s]) begin
         for (int i = 0; i < 100; i++) begin
            applyStimulus(($urandom_range(99) < pushPct[s]),
                          ($urandom_range(99) >= pushPct[s] - 20),
                          DW'($urandom), "random");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
